// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state, opcode, funct and ALU code definitions for the multicycle controller
// Contents: state_e (controller states), OP_* opcodes, F_* R-type funct codes,
// ALU_* operation codes, ctrl_t (datapath strobe bundle), dispatch() for DECODE.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_ORZ = 3'b011;  // OR with zero-extended immediate
  localparam logic [2:0] ALU_LUI = 3'b100;
  localparam logic [2:0] ALU_DEF = 3'b101;  // unrecognised funct
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [4:0] destreg;
  } ctrl_t;

  function automatic state_e dispatch(input logic [5:0] op);
    case (op)
      OP_RTYPE:                 return S_EXEC_R;
      OP_LW, OP_SW:             return S_MEMADR;
      OP_BEQ:                   return S_BRANCH;
      OP_ADDIU, OP_ORI, OP_LUI: return S_EXEC_I;
      OP_J:                     return S_JUMP;
      default:                  return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// rtl/mips_mc_control_if.sv - controller <-> datapath signal bundle
// master: the controller (reads instr/zero/mem_ready, drives strobes, trap, instret).
// slave:  the datapath/memory side (drives instr/zero/mem_ready, reads the rest).
interface mips_mc_control_if #(
  parameter int INSTRET_W = 32
);
  logic [31:0]          instr;
  logic                 zero;
  logic                 mem_ready;
  logic                 irwrite;
  logic                 pcwrite;
  logic                 iord;
  logic                 memread;
  logic                 memwrite;
  logic                 memtoreg;
  logic                 regwrite;
  logic                 alusrca;
  logic [1:0]           alusrcb;
  logic [1:0]           pcsrc;
  logic [2:0]           alucontrol;
  logic [4:0]           destreg;
  logic                 trap;
  logic [INSTRET_W-1:0] instret;

  modport master (
    input  instr, zero, mem_ready,
    output irwrite, pcwrite, iord, memread, memwrite, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, alucontrol, destreg, trap, instret
  );

  modport slave (
    output instr, zero, mem_ready,
    input  irwrite, pcwrite, iord, memread, memwrite, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, alucontrol, destreg, trap, instret
  );
endinterface

// File: rtl/mips_alu_dec.sv
// rtl/mips_alu_dec.sv - combinational ALU operation decoder
// Ports: op_i (instr[31:26]), funct_i (instr[5:0]) -> alucontrol_o.
// R-type decodes funct; I-type decodes opcode (addiu and anything else -> add).
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    if (op_i == OP_RTYPE) begin
      case (funct_i)
        F_ADDU:  alucontrol_o = ALU_ADD;
        F_SUBU:  alucontrol_o = ALU_SUB;
        F_AND:   alucontrol_o = ALU_AND;
        F_OR:    alucontrol_o = ALU_OR;
        F_SLTU:  alucontrol_o = ALU_SLT;
        default: alucontrol_o = ALU_DEF;
      endcase
    end else begin
      case (op_i)
        OP_ORI:  alucontrol_o = ALU_ORZ;
        OP_LUI:  alucontrol_o = ALU_LUI;
        default: alucontrol_o = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multicycle MIPS-subset controller FSM
// Ports: clk, reset_n (async, active-low), bus (mips_mc_control_if.master).
// Parameters: MEM_TIMEOUT (memory wait limit), INSTRET_W (retired counter width).
// Optional macro MIPS_MC_TIMEOUT_EN: trap when a memory access waits MEM_TIMEOUT cycles.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int INSTRET_W   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  mips_mc_control_if.master  bus
);

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_e               state_q, state_d;
  logic [7:0]           wait_q, wait_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 trap_q;
  logic                 tmo;
  logic                 waiting;
  logic                 retire;
  logic [2:0]           alu_dec;
  ctrl_t                ctl;

  logic [31:0] ir;
  logic [5:0]  op;
  assign ir = bus.instr;
  assign op = ir[31:26];

  // rs and shamt never influence control
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[25:21], ir[10:6]};

  mips_alu_dec u_alu_dec (
    .op_i        (op),
    .funct_i     (ir[5:0]),
    .alucontrol_o(alu_dec)
  );

`ifdef MIPS_MC_TIMEOUT_EN
  assign tmo = !bus.mem_ready && (wait_q == TMO);
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE; else if (tmo) state_d = S_TRAP;
      S_DECODE: state_d = dispatch(op);
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB; else if (tmo) state_d = S_TRAP;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH; else if (tmo) state_d = S_TRAP;
      S_EXEC_R: state_d = S_ALUWB;
      S_EXEC_I: state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_TRAP;
    endcase
  end

  // Clearing on every transition covers entry into each wait state; the
  // counter saturates at the limit so it can never wrap back to zero.
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting && !bus.mem_ready && (wait_q != TMO)) begin
      wait_d = wait_q + 8'd1;
    end
  end

  assign retire = (state_q == S_ALUWB) || (state_q == S_MEMWB) || (state_q == S_BRANCH) ||
                  (state_q == S_JUMP)  || ((state_q == S_MEMWR) && bus.mem_ready);
  assign instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      trap_q    <= (state_d == S_TRAP);
    end
  end

  // Strobes decode from the current state; FETCH and BRANCH also look at the
  // same-cycle mem_ready/zero. Everything is held low while reset_n is low.
  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.memread    = 1'b1;
        ctl.alusrcb    = 2'b01;
        ctl.alucontrol = ALU_ADD;
        ctl.irwrite    = bus.mem_ready;
        ctl.pcwrite    = bus.mem_ready;
      end
      S_DECODE: begin
        ctl.alusrcb    = 2'b11;
        ctl.alucontrol = ALU_ADD;
      end
      S_MEMADR: begin
        ctl.alusrca    = 1'b1;
        ctl.alusrcb    = 2'b10;
        ctl.alucontrol = ALU_ADD;
      end
      S_MEMRD: begin
        ctl.iord    = 1'b1;
        ctl.memread = 1'b1;
      end
      S_MEMWB: begin
        ctl.regwrite = 1'b1;
        ctl.memtoreg = 1'b1;
        ctl.destreg  = ir[20:16];
      end
      S_MEMWR: begin
        ctl.iord     = 1'b1;
        ctl.memwrite = 1'b1;
      end
      S_EXEC_R: ctl.alucontrol = alu_dec;
      S_EXEC_I: begin
        ctl.alusrcb    = 2'b10;
        ctl.alucontrol = alu_dec;
      end
      S_ALUWB: begin
        ctl.regwrite = 1'b1;
        ctl.destreg  = (op == OP_RTYPE) ? ir[15:11] : ir[20:16];
      end
      S_BRANCH: begin
        ctl.alucontrol = ALU_SUB;
        ctl.alusrca    = 1'b1;
        ctl.pcsrc      = 2'b01;
        ctl.pcwrite    = bus.zero;
      end
      S_JUMP: begin
        ctl.pcsrc   = 2'b10;
        ctl.pcwrite = 1'b1;
      end
      default: ctl = '0;
    endcase
    if (!reset_n) begin
      ctl = '0;
    end
  end

  assign bus.irwrite    = ctl.irwrite;
  assign bus.pcwrite    = ctl.pcwrite;
  assign bus.iord       = ctl.iord;
  assign bus.memread    = ctl.memread;
  assign bus.memwrite   = ctl.memwrite;
  assign bus.memtoreg   = ctl.memtoreg;
  assign bus.regwrite   = ctl.regwrite;
  assign bus.alusrca    = ctl.alusrca;
  assign bus.alusrcb    = ctl.alusrcb;
  assign bus.pcsrc      = ctl.pcsrc;
  assign bus.alucontrol = ctl.alucontrol;
  assign bus.destreg    = ctl.destreg;
  assign bus.trap       = trap_q;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// tb/tb_mips_mc_control.sv - directed self-checking bench for mips_mc_control
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  int         errors = 0;
  int         checks = 0;
  logic [3:0] exp_ir = 4'd0;

  mips_mc_control_if #(.INSTRET_W(4)) bus ();

  mips_mc_control #(.MEM_TIMEOUT(4), .INSTRET_W(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // {irwrite,pcwrite,iord,memread,memwrite,memtoreg,regwrite,alusrca}, alusrcb, pcsrc, alucontrol
  logic [14:0] obs_ctl;
  assign obs_ctl = {bus.irwrite, bus.pcwrite, bus.iord, bus.memread, bus.memwrite, bus.memtoreg,
                    bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol};

  localparam logic [14:0] C_FETCH_RDY  = {8'b1101_0000, 2'b01, 2'b00, 3'b010};
  localparam logic [14:0] C_FETCH_WAIT = {8'b0001_0000, 2'b01, 2'b00, 3'b010};
  localparam logic [14:0] C_DECODE     = {8'b0000_0000, 2'b11, 2'b00, 3'b010};
  localparam logic [14:0] C_MEMADR     = {8'b0000_0001, 2'b10, 2'b00, 3'b010};
  localparam logic [14:0] C_MEMRD      = {8'b0011_0000, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] C_MEMWB      = {8'b0000_0110, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] C_MEMWR      = {8'b0010_1000, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] C_ALUWB      = {8'b0000_0010, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] C_BR_T       = {8'b0100_0001, 2'b00, 2'b01, 3'b110};
  localparam logic [14:0] C_BR_N       = {8'b0000_0001, 2'b00, 2'b01, 3'b110};
  localparam logic [14:0] C_JUMP       = {8'b0100_0000, 2'b00, 2'b10, 3'b000};
  localparam logic [14:0] C_NONE       = 15'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic at(input string tag, input logic mr, input logic z, input logic [14:0] exp);
    bus.mem_ready = mr;
    bus.zero      = z;
    #1;
    chk(tag, {17'd0, obs_ctl}, {17'd0, exp});
  endtask

  task automatic fetch_decode(input string tag, input logic [31:0] iw);
    bus.instr = iw;
    at({tag, ".fetch"}, 1'b1, 1'b0, C_FETCH_RDY);
    chk({tag, ".instret"}, {28'd0, bus.instret}, {28'd0, exp_ir});
    nxt();
    at({tag, ".decode"}, 1'b1, 1'b0, C_DECODE);
    nxt();
  endtask

  task automatic alu_instr(input string tag, input logic [31:0] iw, input logic [1:0] srcb,
                           input logic [2:0] alu, input logic [4:0] dreg);
    fetch_decode(tag, iw);
    at({tag, ".exec"}, 1'b1, 1'b0, {8'h00, srcb, 2'b00, alu});
    nxt();
    at({tag, ".aluwb"}, 1'b1, 1'b0, C_ALUWB);
    chk({tag, ".destreg"}, {27'd0, bus.destreg}, {27'd0, dreg});
    exp_ir++;
    nxt();
  endtask

  task automatic jump_instr(input string tag);
    fetch_decode(tag, 32'h0800_0000);
    at({tag, ".jump"}, 1'b1, 1'b0, C_JUMP);
    exp_ir++;
    nxt();
  endtask

  initial begin
    bus.instr     = 32'd0;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;

    // reset state
    #3;
    chk("reset.ctl", {17'd0, obs_ctl}, 32'd0);
    chk("reset.trap", {31'd0, bus.trap}, 32'd0);
    chk("reset.instret", {28'd0, bus.instret}, 32'd0);
    chk("reset.destreg", {27'd0, bus.destreg}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // R-type and I-type ALU instructions
    alu_instr("addu",  32'h0085_1021, 2'b00, 3'b010, 5'd2);
    alu_instr("subu",  32'h0085_1823, 2'b00, 3'b110, 5'd3);
    alu_instr("and",   32'h0085_2024, 2'b00, 3'b000, 5'd4);
    alu_instr("fother",32'h0085_3020, 2'b00, 3'b101, 5'd6);
    alu_instr("ori",   32'h34A3_00FF, 2'b10, 3'b011, 5'd3);
    alu_instr("lui",   32'h3C07_1234, 2'b10, 3'b100, 5'd7);
    alu_instr("addiu", 32'h24E5_FFFF, 2'b10, 3'b010, 5'd5);

    // lw with three wait cycles in MEMRD
    fetch_decode("lw", 32'h8C88_0004);
    at("lw.memadr", 1'b1, 1'b0, C_MEMADR);
    nxt();
    for (int i = 0; i < 3; i++) begin
      at("lw.memrd_wait", 1'b0, 1'b0, C_MEMRD);
      nxt();
    end
    at("lw.memrd_done", 1'b1, 1'b0, C_MEMRD);
    nxt();
    at("lw.memwb", 1'b1, 1'b0, C_MEMWB);
    chk("lw.destreg", {27'd0, bus.destreg}, 32'd8);
    exp_ir++;
    nxt();

    // sw with one wait cycle; instret must not move while waiting
    fetch_decode("sw", 32'hAC88_0004);
    at("sw.memadr", 1'b1, 1'b0, C_MEMADR);
    nxt();
    at("sw.memwr_wait", 1'b0, 1'b0, C_MEMWR);
    nxt();
    chk("sw.instret_hold", {28'd0, bus.instret}, {28'd0, exp_ir});
    at("sw.memwr_done", 1'b1, 1'b0, C_MEMWR);
    exp_ir++;
    nxt();

    // beq taken and not taken both retire
    fetch_decode("beq_t", 32'h1000_0003);
    at("beq_t.branch", 1'b1, 1'b1, C_BR_T);
    exp_ir++;
    nxt();
    fetch_decode("beq_n", 32'h1000_0003);
    at("beq_n.branch", 1'b1, 1'b0, C_BR_N);
    exp_ir++;
    nxt();

    // 11 retired so far: 5 jumps reach 16 -> 0, then 16 more wrap back to 0
    for (int i = 0; i < 5; i++) jump_instr("j_a");
    chk("instret.wrap1", {28'd0, bus.instret}, 32'd0);
    for (int i = 0; i < 16; i++) jump_instr("j_b");
    chk("instret.wrap2", {28'd0, bus.instret}, 32'd0);

    // illegal opcode traps and stays trapped
    fetch_decode("ill", 32'hFC00_0000);
    for (int i = 0; i < 10; i++) begin
      at("ill.trap_ctl", 1'b1, 1'b1, C_NONE);
      chk("ill.trap", {31'd0, bus.trap}, 32'd1);
      chk("ill.instret_frozen", {28'd0, bus.instret}, {28'd0, exp_ir});
      nxt();
    end

    // reset pulse clears trap and counter, strobes low during reset
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst2.ctl", {17'd0, obs_ctl}, 32'd0);
    chk("rst2.trap", {31'd0, bus.trap}, 32'd0);
    chk("rst2.instret", {28'd0, bus.instret}, 32'd0);
    nxt();
    reset_n = 1'b1;
    exp_ir = 4'd0;

    // memory never ready in FETCH
    at("to.fetch_c1", 1'b0, 1'b0, C_FETCH_WAIT);
    for (int i = 0; i < 4; i++) begin
      nxt();
      at("to.fetch_wait", 1'b0, 1'b0, C_FETCH_WAIT);
      chk("to.trap_low", {31'd0, bus.trap}, 32'd0);
    end
    nxt();
`ifdef MIPS_MC_TIMEOUT_EN
    at("to.trap_ctl", 1'b0, 1'b0, C_NONE);
    chk("to.trap", {31'd0, bus.trap}, 32'd1);
`else
    for (int i = 0; i < 8; i++) begin
      at("to.still_fetch", 1'b0, 1'b0, C_FETCH_WAIT);
      chk("to.no_trap", {31'd0, bus.trap}, 32'd0);
      nxt();
    end
    fetch_decode("late", 32'h0800_0000);
    at("late.jump", 1'b1, 1'b0, C_JUMP);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max wait cycles on mem_ready before trap (range 1..255).
REQ-002 Parameter INSTRET_W, default 32, width of retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 instr  input  32  instruction word; valid from cycle after irwrite.
REQ-006 zero  input  1  ALU result is zero.
REQ-007 mem_ready  input  1  memory completes the current access this cycle.
REQ-008 irwrite, pcwrite, iord, memread, memwrite, memtoreg, regwrite, alusrca  output  1 each  datapath strobes and selects.
REQ-009 alusrcb  output  2  ALU operand B select: 00 reg, 01 const 4, 10 imm, 11 imm<<2.
REQ-010 pcsrc  output  2  next PC: 00 ALU, 01 ALUOut (branch target), 10 jump target.
REQ-011 alucontrol  output  3  ALU operation code.
REQ-012 destreg  output  5  target register number.
REQ-013 trap  output  1  sticky; illegal opcode or memory timeout.
REQ-014 instret  output  INSTRET_W  count of retired instructions.

Function
REQ-015 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP, TRAP.
REQ-016 FETCH: iord=0, memread=1, alusrca=0, alusrcb=01, alucontrol=010; stay while mem_ready=0; on mem_ready=1 pulse irwrite and pcwrite (pcsrc=00), go DECODE.
REQ-017 DECODE: alusrcb=11, alucontrol=010 (branch target precompute); dispatch on instr[31:26].
REQ-018 Dispatch: 000000->EXEC_R; 100011/101011->MEMADR; 000100->BRANCH; 001001/001101/001111->EXEC_I; 000010->JUMP; any other->TRAP.
REQ-019 EXEC_R alucontrol from funct: 100001->010, 100011->110, 100100->000, 100101->001, 101011->111, other->101; then ALUWB with destreg=instr[15:11].
REQ-020 EXEC_I alusrcb=10; addiu->010, ori->011, lui->100; then ALUWB with destreg=instr[20:16].
REQ-021 MEMADR alusrca=1, alusrcb=10, alucontrol=010; lw->MEMRD, sw->MEMWR.
REQ-022 MEMRD iord=1, memread=1, hold until mem_ready, then MEMWB (regwrite=1, memtoreg=1, destreg=instr[20:16]).
REQ-023 MEMWR iord=1, memwrite=1, hold until mem_ready, then FETCH.
REQ-024 BRANCH alucontrol=110, alusrca=1, alusrcb=00, pcsrc=01, pcwrite=zero; -> FETCH.
REQ-025 JUMP pcsrc=10, pcwrite=1; -> FETCH.
REQ-026 Every strobe not listed for a state SHALL be 0; regwrite/memwrite/pcwrite never X.
REQ-027 instret SHALL increment by 1 on exit from ALUWB, MEMWB, MEMWR, BRANCH, JUMP; wraps modulo 2^INSTRET_W.
REQ-028 TRAP: all strobes 0, trap=1, no exit except reset; instret frozen.
REQ-029 Memory wait counter resets on entry to FETCH/MEMRD/MEMWR; mem_ready in the first cycle completes with zero wait.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state FETCH, trap=0, instret=0, wait counter=0, all strobes 0 during reset.
REQ-031 Reset asserted mid-access SHALL abort it; first fetch restarts one cycle after reset_n deasserts.

Configuration
REQ-032 Macro MIPS_MC_TIMEOUT_EN defined: if wait counter reaches MEM_TIMEOUT with mem_ready=0, go TRAP next cycle; undefined: wait indefinitely, MEM_TIMEOUT unused.

Structure
REQ-033 Shared package mips_pkg SHALL hold state enum, opcode/funct constants and ALU code constants.
REQ-034 Sub-module mips_alu_dec (funct/opcode -> alucontrol, combinational) SHALL be instantiated once.

Verification
REQ-035 addu 0x00851021, mem_ready=1 always -> regwrite=1 in cycle 4 (ALUWB), destreg=2, alucontrol=010 in EXEC_R, instret=1.
REQ-036 lw 0x8C880004 with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then regwrite=1, memtoreg=1, destreg=8.
REQ-037 beq 0x10000003, zero=1 -> pcwrite=1, pcsrc=01 in BRANCH; zero=0 -> pcwrite=0; instret increments both cases.
REQ-038 opcode 0x3F -> TRAP after DECODE, trap=1, all strobes 0 for 10 cycles; reset_n pulse -> FETCH, trap=0.
REQ-039 MIPS_MC_TIMEOUT_EN, MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> trap=1 after 5 cycles; without macro -> stays FETCH.
REQ-040 INSTRET_W=4, 16 jumps -> instret wraps to 0.
